// File: rtl/jt12_mix_pkg.sv
// Shared types and width/limit helpers for the sequential channel mixer.
package jt12_mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } mix_state_t;

    // Accumulator wide enough that CH full-scale products can never wrap.
    function automatic int acc_width(input int win, input int gw, input int ch);
        return win + gw + 1 + $clog2(ch);
    endfunction

    // Channel index width; at least one bit even for degenerate channel counts.
    function automatic int idx_width(input int ch);
        return (ch < 2) ? 1 : $clog2(ch);
    endfunction

    function automatic longint max_pos(input int wout);
        return (longint'(1) <<< (wout - 1)) - 1;
    endfunction

    function automatic longint min_neg(input int wout);
        return -(longint'(1) <<< (wout - 1));
    endfunction

endpackage

// File: rtl/jt12_mix_sat.sv
// Drops the gain's fractional bits with an arithmetic shift (floor toward
// -inf, no rounding) and clamps the result into a signed WOUT-bit range.
module jt12_mix_sat
    import jt12_mix_pkg::*;
#(
    parameter int IW    = 27,
    parameter int GFRAC = 4,
    parameter int WOUT  = 20
) (
    input  logic signed [IW-1:0]   value_in,
    output logic signed [WOUT-1:0] value_out,
    output logic                   clip
);

    localparam longint MAXP = max_pos(WOUT);
    localparam longint MINN = min_neg(WOUT);

    logic signed [IW-1:0] shifted;
    longint               wide;

    // Shift, widen to a common signed width, then clamp against the output limits.
    always_comb begin
        shifted   = value_in >>> GFRAC;
        wide      = longint'(shifted);
        clip      = 1'b0;
        value_out = WOUT'(wide);
        if (wide > MAXP) begin
            value_out = WOUT'(MAXP);
            clip      = 1'b1;
        end else if (wide < MINN) begin
            value_out = WOUT'(MINN);
            clip      = 1'b1;
        end
    end

endmodule

// File: rtl/jt12_mixer_seq.sv
// Time-multiplexed gain mixer: one shared multiplier walks the channels of a
// snapshot taken on cen, then the sum is scaled, saturated and presented.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for cen; snapshot inputs and start a mix on cen
//   ACC   | add one channel's gained contribution per clock
//   SAT   | scale + clamp the sum, update mixed/clip, pulse valid
module jt12_mixer_seq
    import jt12_mix_pkg::*;
#(
    parameter int CH    = 4,
    parameter int WIN   = 16,
    parameter int GW    = 8,
    parameter int GFRAC = 4,
    parameter int WOUT  = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic [CH*WIN-1:0]      ch,
    input  logic [CH*GW-1:0]       gain,
    input  logic [CH-1:0]          ch_en,
    output logic signed [WOUT-1:0] mixed,
    output logic                   valid,
    output logic                   clip,
    output logic                   busy,
    output logic                   overrun
);

    localparam int PW  = WIN + GW + 1;
    localparam int AW  = acc_width(WIN, GW, CH);
    localparam int IXW = idx_width(CH);
    localparam logic [IXW-1:0] LAST_IDX = IXW'(CH - 1);

    mix_state_t            state;
    logic signed [WIN-1:0] ch_q   [CH];
    logic [GW-1:0]         gain_q [CH];
    logic [CH-1:0]         en_q;
    logic [IXW-1:0]        idx;
    logic signed [AW-1:0]  acc;

    logic signed [PW-1:0]   ch_x;
    logic signed [PW-1:0]   gain_x;
    logic signed [PW-1:0]   prod;
    logic signed [WOUT-1:0] sat_val;
    logic                   sat_clip;

    // Shared multiplier: current channel times its gain, zero when disabled.
    always_comb begin
        ch_x   = PW'(ch_q[idx]);
        gain_x = PW'({1'b0, gain_q[idx]});
        prod   = '0;
        if (en_q[idx]) begin
            prod = ch_x * gain_x;
        end
    end

    jt12_mix_sat #(
        .IW    (AW),
        .GFRAC (GFRAC),
        .WOUT  (WOUT)
    ) u_sat (
        .value_in  (acc),
        .value_out (sat_val),
        .clip      (sat_clip)
    );

    // Sequencer with registered outputs; a cen arriving mid-mix only flags overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            mixed   <= '0;
            valid   <= 1'b0;
            clip    <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (cen) begin
                        for (int i = 0; i < CH; i++) begin
                            ch_q[i]   <= ch[i*WIN +: WIN];
                            gain_q[i] <= gain[i*GW +: GW];
                        end
                        en_q  <= ch_en;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    overrun <= cen;
                    acc     <= acc + AW'(prod);
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= SAT;
                    end else begin
                        idx <= idx + IXW'(1);
                    end
                end
                SAT: begin
                    overrun <= cen;
                    mixed   <= sat_val;
                    clip    <= sat_clip;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt12_mixer_seq.sv
// Self-checking bench for jt12_mixer_seq with a plain-arithmetic reference model.
module tb_jt12_mixer_seq;

    localparam int CH    = 4;
    localparam int WIN   = 16;
    localparam int GW    = 8;
    localparam int GFRAC = 4;
    localparam int WOUT  = 20;
    localparam longint MAXP = 524287;
    localparam longint MINN = -524288;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cen;
    logic [CH*WIN-1:0]      ch;
    logic [CH*GW-1:0]       gain;
    logic [CH-1:0]          ch_en;
    logic signed [WOUT-1:0] mixed;
    logic                   valid;
    logic                   clip;
    logic                   busy;
    logic                   overrun;

    int errors = 0;
    int checks = 0;

    int          chv [CH];
    int          gv  [CH];
    logic [CH-1:0] env;
    longint      exp_mix;
    logic        exp_clip;
    longint      exp_a;
    logic        exp_a_clip;

    always #5 clk = ~clk;

    jt12_mixer_seq #(
        .CH(CH), .WIN(WIN), .GW(GW), .GFRAC(GFRAC), .WOUT(WOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .ch      (ch),
        .gain    (gain),
        .ch_en   (ch_en),
        .mixed   (mixed),
        .valid   (valid),
        .clip    (clip),
        .busy    (busy),
        .overrun (overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: sum of enabled ch*gain, floor-divide by 2^GFRAC, clamp.
    task automatic model();
        longint s;
        s = 0;
        for (int i = 0; i < CH; i++)
            if (env[i]) s += longint'(chv[i]) * longint'(gv[i]);
        s = s >>> GFRAC;
        exp_clip = 1'b0;
        if (s > MAXP) begin s = MAXP; exp_clip = 1'b1; end
        else if (s < MINN) begin s = MINN; exp_clip = 1'b1; end
        exp_mix = s;
    endtask

    task automatic apply();
        for (int i = 0; i < CH; i++) begin
            ch[i*WIN +: WIN]  = chv[i][WIN-1:0];
            gain[i*GW +: GW]  = gv[i][GW-1:0];
        end
        ch_en = env;
    endtask

    task automatic rand_data(input int gmax);
        for (int i = 0; i < CH; i++) begin
            chv[i] = int'($urandom_range(65535)) - 32768;
            gv[i]  = int'($urandom_range(gmax));
        end
        env = CH'($urandom);
    endtask

    task automatic set4(input int c0, input int c1, input int c2, input int c3,
                        input int g0, input int g1, input int g2, input int g3,
                        input logic [3:0] en);
        chv[0] = c0; chv[1] = c1; chv[2] = c2; chv[3] = c3;
        gv[0]  = g0; gv[1]  = g1; gv[2]  = g2; gv[3]  = g3;
        env    = en;
    endtask

    // Full mix with cycle-exact checks of busy/valid/mixed/clip.
    task automatic run_mix(input string tag);
        model();
        apply();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        rand_data(255);
        apply();
        for (int k = 1; k <= CH; k++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_novalid"}, valid, 0);
            tick();
        end
        chk({tag, "_busy_last"}, busy, 1);
        tick();
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_mixed"}, mixed, exp_mix);
        chk({tag, "_clip"}, clip, exp_clip);
        chk({tag, "_busy_done"}, busy, 0);
        tick();
        chk({tag, "_valid_pulse"}, valid, 0);
        chk({tag, "_mixed_hold"}, mixed, exp_mix);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; ch = '0; gain = '0; ch_en = '0;
        repeat (3) tick();
        chk("rst_mixed", mixed, 0);
        chk("rst_valid", valid, 0);
        chk("rst_clip", clip, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        set4(1000, 2000, -500, 3, 16, 16, 16, 16, 4'b1111);
        run_mix("unity");
        set4(32767, 32767, 32767, 32767, 255, 255, 255, 255, 4'b1111);
        run_mix("sat_pos");
        set4(-32768, -32768, -32768, -32768, 255, 255, 255, 255, 4'b1111);
        run_mix("sat_neg");
        set4(-1, 5000, 5000, 5000, 1, 0, 0, 0, 4'b1111);
        run_mix("floor_neg");
        set4(1, 5000, 5000, 5000, 1, 0, 0, 0, 4'b1111);
        run_mix("floor_pos");
        set4(1000, 2000, -500, 3, 16, 16, 16, 16, 4'b1011);
        run_mix("enable_mask");
        set4(30000, -30000, 1234, 777, 200, 100, 50, 25, 4'b0000);
        run_mix("all_off");

        for (int n = 0; n < 24; n++) begin
            rand_data((n % 3 == 0) ? 255 : 40);
            run_mix("random");
        end

        // Overrun: cen during ACC and during SAT are dropped; the mix keeps E0's data.
        set4(1000, 2000, -500, 3, 16, 16, 16, 16, 4'b1111);
        model();
        exp_a = exp_mix; exp_a_clip = exp_clip;
        apply();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        chk("ovr_busy_e0", busy, 1);
        chk("ovr_quiet_e0", overrun, 0);
        tick();
        set4(7000, -7000, 100, 200, 32, 32, 32, 32, 4'b1111);
        apply();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        chk("ovr_pulse_e2", overrun, 1);
        tick();
        chk("ovr_pulse_end", overrun, 0);
        tick();
        cen = 1'b1;
        tick();
        chk("ovr_valid_e5", valid, 1);
        chk("ovr_mixed_e5", mixed, exp_a);
        chk("ovr_clip_e5", clip, exp_a_clip);
        chk("ovr_sat_pulse", overrun, 1);
        model();
        tick();
        cen = 1'b0;
        chk("ovr_accept_e6", busy, 1);
        chk("ovr_accept_quiet", overrun, 0);
        rand_data(255);
        apply();
        for (int k = 7; k <= 10; k++) begin
            tick();
            chk("ovr_b_novalid", valid, 0);
        end
        tick();
        chk("ovr_b_valid", valid, 1);
        chk("ovr_b_mixed", mixed, exp_mix);
        tick();

        // Reset mid-mix aborts; a later cen mixes normally.
        set4(9000, 9000, 9000, 9000, 64, 64, 64, 64, 4'b1111);
        apply();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mixed", mixed, 0);
        chk("abort_valid", valid, 0);
        chk("abort_clip", clip, 0);
        tick();
        chk("abort_idle", busy, 0);
        set4(-12000, 3000, 25000, -7, 100, 17, 3, 255, 4'b1101);
        model();
        apply();
        cen = 1'b1;
        tick();
        cen = 1'b0;
        chk("restart_busy", busy, 1);
        for (int k = 5; k <= 8; k++) begin
            tick();
            chk("restart_novalid", valid, 0);
        end
        tick();
        chk("restart_valid", valid, 1);
        chk("restart_mixed", mixed, exp_mix);
        chk("restart_clip", clip, exp_clip);
        tick();

        // rst wins over cen in the same cycle.
        rand_data(255);
        apply();
        rst = 1'b1;
        cen = 1'b1;
        tick();
        rst = 1'b0;
        cen = 1'b0;
        chk("prio_busy", busy, 0);
        for (int k = 0; k <= CH + 1; k++) begin
            tick();
            chk("prio_novalid", valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
